// File: rtl/key_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_repeat
// Description : Per-key two-flop synchronizer, stability-count debouncer and
//               IDLE/HOLD/REPEAT auto-repeat engine for active-low buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_repeat #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY,
    input  logic [N_KEYS-1:0] REPEAT_EN,
    output logic [N_KEYS-1:0] KEY_STATE,
    output logic [N_KEYS-1:0] PRESS,
    output logic [N_KEYS-1:0] RELEASE
);

    // One counter width covers all three intervals.
    localparam int c_MAX_A     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX_PARAM = (c_MAX_A > REPEAT_RATE) ? c_MAX_A : REPEAT_RATE;
    localparam int c_CNT_W     = $clog2(c_MAX_PARAM) + 1;

    // Terminal values: an event fires when the old count equals interval-1.
    localparam logic [c_CNT_W-1:0] c_DEB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DELAY_LAST = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RATE_LAST  = c_CNT_W'(REPEAT_RATE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_key
            logic               r_sync1;
            logic               r_sync2;
            logic               r_key_state;
            logic               r_press;
            logic               r_release;
            logic [c_CNT_W-1:0] r_stab_cnt;
            logic [c_CNT_W-1:0] r_rep_cnt;
            rep_state_t         r_fsm;

            logic               w_level;
            logic               w_differs;
            logic               w_accept;

            // Synchronized level is active-high; the raw button is active-low.
            assign w_level   = ~r_sync2;
            assign w_differs = w_level ^ r_key_state;
            assign w_accept  = w_differs && (r_stab_cnt >= c_DEB_LAST);

            // Two-flop synchronizer, reset to the released level.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                end else begin
                    r_sync1 <= KEY[i];
                    r_sync2 <= r_sync1;
                end
            end

            // Debounce counter plus repeat FSM with registered pulse outputs.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_key_state <= 1'b0;
                    r_press     <= 1'b0;
                    r_release   <= 1'b0;
                    r_stab_cnt  <= '0;
                    r_rep_cnt   <= '0;
                    r_fsm       <= ST_IDLE;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= w_accept && !w_level;

                    if (!w_differs) begin
                        r_stab_cnt <= '0;
                    end else if (w_accept) begin
                        r_stab_cnt  <= '0;
                        r_key_state <= w_level;
                    end else if (r_stab_cnt != c_CNT_MAX) begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end

                    case (r_fsm)
                        ST_IDLE: begin
                            if (w_accept && w_level) begin
                                r_press   <= 1'b1;
                                r_rep_cnt <= '0;
                                r_fsm     <= ST_HOLD;
                            end
                        end
                        ST_HOLD, ST_REPEAT: begin
                            if (w_accept && !w_level) begin
                                r_rep_cnt <= '0;
                                r_fsm     <= ST_IDLE;
                            end else if (!REPEAT_EN[i]) begin
                                r_rep_cnt <= '0;
                            end else if (r_rep_cnt >= ((r_fsm == ST_HOLD) ? c_DELAY_LAST : c_RATE_LAST)) begin
                                r_press   <= 1'b1;
                                r_rep_cnt <= '0;
                                r_fsm     <= ST_REPEAT;
                            end else if (r_rep_cnt != c_CNT_MAX) begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_rep_cnt <= '0;
                            r_fsm     <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign KEY_STATE[i] = r_key_state;
            assign PRESS[i]     = r_press;
            assign RELEASE[i]   = r_release;
        end
    endgenerate

endmodule
`default_nettype wire
